// File: rtl/char_pkg.sv
// Shared types and constants for the character-overlay drawing stage.
package char_pkg;

  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned CHAR_H    = 16;
  localparam int unsigned TEXT_COLS = 16;
  localparam int unsigned TEXT_ROWS = 16;
  localparam int unsigned HCNT_W    = 11;
  localparam int unsigned RGB_W     = 12;

  // Text rectangle size in pixels.
  localparam int unsigned RECT_W = CHAR_W * TEXT_COLS;
  localparam int unsigned RECT_H = CHAR_H * TEXT_ROWS;

  // Cycles the side pipeline must cover: stage 0 register plus two ROM reads.
  localparam int unsigned SIDE_DEL = 3;

  typedef struct packed {
    logic [HCNT_W-1:0] vcount;
    logic              vsync;
    logic              vblnk;
    logic [HCNT_W-1:0] hcount;
    logic              hsync;
    logic              hblnk;
  } vga_timing_t;

  // Everything that has to travel alongside the ROM lookups.
  typedef struct packed {
    vga_timing_t      timing;
    logic [RGB_W-1:0] rgb;
    logic             in_rect;
    logic [2:0]       dx_lo;
  } side_t;

  // Font rows are stored MSB-first: bit 7 is the leftmost pixel.
  function automatic logic font_bit(logic [CHAR_W-1:0] row, logic [2:0] x);
    return row[3'd7 - x];
  endfunction

endpackage

// File: rtl/delay.sv
// Fixed-length shift-register delay line with synchronous active-high clear.
module delay #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [CLK_DEL];

  // Shift chain; reset clears every stage so no stale data survives a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(CLK_DEL); i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(CLK_DEL); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[CLK_DEL-1];

endmodule

// File: rtl/draw_rect_char.sv
// Character-ROM initiator: overlays a 16x16-character text rectangle on a VGA
// stream. Issues char_xy/char_line, consumes the font row two cycles later, and
// delays timing and colour so every output lags the inputs by 4 clocks.
// Optional build macro DRAW_RECT_CHAR_BG_EN: fill unset font pixels inside the
// rectangle with BG_COLOR instead of passing the incoming colour.
module draw_rect_char
  import char_pkg::*;
#(
  parameter logic [HCNT_W-1:0] XPOS       = 11'd48,
  parameter logic [HCNT_W-1:0] YPOS       = 11'd64,
  parameter logic [RGB_W-1:0]  TEXT_COLOR = 12'hFF0,
  parameter logic [RGB_W-1:0]  BG_COLOR   = 12'h008
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HCNT_W-1:0] vcount_in,
  input  logic              vsync_in,
  input  logic              vblnk_in,
  input  logic [HCNT_W-1:0] hcount_in,
  input  logic              hsync_in,
  input  logic              hblnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  output logic [7:0]        char_xy,
  output logic [3:0]        char_line,
  input  logic [7:0]        char_pixels,
  output logic [HCNT_W-1:0] vcount_out,
  output logic              vsync_out,
  output logic              vblnk_out,
  output logic [HCNT_W-1:0] hcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic [RGB_W-1:0]  rgb_out
);

`ifdef DRAW_RECT_CHAR_BG_EN
  localparam bit BG_EN = 1'b1;
`else
  localparam bit BG_EN = 1'b0;
`endif

  // One spare bit so XPOS+RECT_W near the top of the counter range cannot wrap.
  localparam logic [HCNT_W:0] RECT_W_EXT = (HCNT_W+1)'(RECT_W);
  localparam logic [HCNT_W:0] RECT_H_EXT = (HCNT_W+1)'(RECT_H);
  localparam logic [HCNT_W:0] X_LO = {1'b0, XPOS};
  localparam logic [HCNT_W:0] Y_LO = {1'b0, YPOS};
  localparam logic [HCNT_W:0] X_HI = X_LO + RECT_W_EXT;
  localparam logic [HCNT_W:0] Y_HI = Y_LO + RECT_H_EXT;

  logic [HCNT_W:0] h_ext;
  logic [HCNT_W:0] v_ext;
  logic            in_rect;
  logic [6:0]      dx;     // offset within the 128-pixel-wide rectangle
  logic [7:0]      dy;     // offset within the 256-line-tall rectangle

  side_t           side_in;
  side_t           side_d;
  logic [$bits(side_t)-1:0] side_q_vec;

  logic             pix_set;
  logic [RGB_W-1:0] rgb_next;

  // Rectangle hit test and in-rectangle offsets; offsets are only consumed
  // when in_rect, so the wrap for pixels left of/above the box is harmless.
  always_comb begin
    h_ext   = {1'b0, hcount_in};
    v_ext   = {1'b0, vcount_in};
    in_rect = (h_ext >= X_LO) && (h_ext < X_HI) &&
              (v_ext >= Y_LO) && (v_ext < Y_HI) &&
              !hblnk_in && !vblnk_in;
    dx      = 7'(hcount_in - XPOS);
    dy      = 8'(vcount_in - YPOS);
  end

  // Stage 0: character address and line to the ROMs, zero outside the box.
  always_ff @(posedge clk) begin
    if (rst || !in_rect) begin
      char_xy   <= 8'h00;
      char_line <= 4'h0;
    end else begin
      char_xy   <= {dx[6:3], dy[7:4]};
      char_line <= dy[3:0];
    end
  end

  // Bundle the values that must line up with the returning font row.
  always_comb begin
    side_in.timing.vcount = vcount_in;
    side_in.timing.vsync  = vsync_in;
    side_in.timing.vblnk  = vblnk_in;
    side_in.timing.hcount = hcount_in;
    side_in.timing.hsync  = hsync_in;
    side_in.timing.hblnk  = hblnk_in;
    side_in.rgb           = rgb_in;
    side_in.in_rect       = in_rect;
    side_in.dx_lo         = dx[2:0];
  end

  delay #(
    .WIDTH  ($bits(side_t)),
    .CLK_DEL(SIDE_DEL)
  ) u_side_delay (
    .clk(clk),
    .rst(rst),
    .d  (side_in),
    .q  (side_q_vec)
  );

  assign side_d = side_t'(side_q_vec);

  // Colour selection against the font row that arrives this cycle.
  always_comb begin
    pix_set  = font_bit(char_pixels, side_d.dx_lo);
    rgb_next = side_d.rgb;
    if (side_d.in_rect) begin
      if (pix_set) begin
        rgb_next = TEXT_COLOR;
      end else if (BG_EN) begin
        rgb_next = BG_COLOR;
      end
    end
  end

  // Output register: timing and colour leave together.
  always_ff @(posedge clk) begin
    if (rst) begin
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      vcount_out <= side_d.timing.vcount;
      vsync_out  <= side_d.timing.vsync;
      vblnk_out  <= side_d.timing.vblnk;
      hcount_out <= side_d.timing.hcount;
      hsync_out  <= side_d.timing.hsync;
      hblnk_out  <= side_d.timing.hblnk;
      rgb_out    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_draw_rect_char.sv
// Scoreboard bench for draw_rect_char with behavioural character/font ROMs.
module tb_draw_rect_char;
  import char_pkg::*;

  localparam int XP = 48;
  localparam int YP = 64;
  localparam logic [11:0] TEXT = 12'hFF0;
  localparam logic [11:0] BG   = 12'h008;
`ifdef DRAW_RECT_CHAR_BG_EN
  localparam bit BG_ON = 1'b1;
`else
  localparam bit BG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [10:0] vcount_in = '0, hcount_in = '0;
  logic        vsync_in = 1'b0, vblnk_in = 1'b0, hsync_in = 1'b0, hblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels = '0;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic [11:0] rgb_out;

  draw_rect_char dut (
    .clk        (clk),
    .rst        (rst),
    .vcount_in  (vcount_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .hcount_in  (hcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .rgb_in     (rgb_in),
    .char_xy    (char_xy),
    .char_line  (char_line),
    .char_pixels(char_pixels),
    .vcount_out (vcount_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .hcount_out (hcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .rgb_out    (rgb_out)
  );

  // Model ROMs: character code depends on position, font row on code and line.
  function automatic logic [7:0] char_code(logic [7:0] xy);
    return xy ^ 8'h41;
  endfunction

  function automatic logic [7:0] font(logic [7:0] c, logic [3:0] l);
    return (c * 8'd13) ^ ({4'd0, l} * 8'd29) ^ 8'h5A;
  endfunction

  logic [7:0] code_q = '0;
  logic [3:0] line_q = '0;
  always @(posedge clk) begin
    code_q      <= char_code(char_xy);
    line_q      <= char_line;
    char_pixels <= font(code_q, line_q);
  end

  typedef struct {
    bit          rst;
    int          h;
    int          v;
    bit          hs, vs, hb, vb;
    logic [11:0] rgb;
  } in_t;

  typedef struct {
    int          due;
    logic [7:0]  xy;
    logic [3:0]  line;
  } xy_exp_t;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    vga_timing_t t;
  } out_exp_t;

  xy_exp_t  xq[$];
  out_exp_t oq[$];
  in_t      hist[$];
  int       edge_cnt = 0;
  int       n_checks = 0;
  int       n_fail   = 0;

  function automatic bit inside_rect(in_t x);
    return x.h >= XP && x.h < XP + 128 && x.v >= YP && x.v < YP + 256 && !x.hb && !x.vb;
  endfunction

  // Reference colour from the text-grid rules.
  function automatic logic [11:0] model_rgb(in_t x);
    int         col, row, line, px;
    logic [7:0] pix;
    if (!inside_rect(x)) return x.rgb;
    col  = (x.h - XP) / 8;
    row  = (x.v - YP) / 16;
    line = (x.v - YP) % 16;
    px   = (x.h - XP) % 8;
    pix  = font(char_code(8'(col * 16 + row)), 4'(line));
    if (pix[7 - px]) return TEXT;
    return BG_ON ? BG : x.rgb;
  endfunction

  // Drive one pixel at the negedge and push the expectations it implies.
  task automatic step(in_t x);
    xy_exp_t  ex;
    out_exp_t eo;
    bit       any_rst;
    @(negedge clk);
    rst       = x.rst;
    hcount_in = 11'(x.h);
    vcount_in = 11'(x.v);
    hsync_in  = x.hs;
    vsync_in  = x.vs;
    hblnk_in  = x.hb;
    vblnk_in  = x.vb;
    rgb_in    = x.rgb;
    ex.due = edge_cnt + 1;
    if (!x.rst && inside_rect(x)) begin
      ex.xy   = {4'((x.h - XP) / 8), 4'((x.v - YP) / 16)};
      ex.line = 4'((x.v - YP) % 16);
    end else begin
      ex.xy   = 8'h00;
      ex.line = 4'h0;
    end
    xq.push_back(ex);
    hist.push_back(x);
    while (hist.size() > 4) void'(hist.pop_front());
    any_rst = 1'b0;
    foreach (hist[i]) any_rst |= hist[i].rst;
    eo.due = edge_cnt + 1;
    if (any_rst) begin
      eo.rgb = '0;
      eo.t   = '0;
    end else begin
      eo.rgb = model_rgb(hist[0]);
      eo.t   = {11'(hist[0].v), hist[0].vs, hist[0].vb, 11'(hist[0].h), hist[0].hs, hist[0].hb};
    end
    oq.push_back(eo);
  endtask

  function automatic in_t mk(bit r, int h, int v, bit hb, bit vb, logic [11:0] c);
    in_t x;
    x.rst = r; x.h = h; x.v = v; x.hb = hb; x.vb = vb; x.rgb = c;
    x.hs = 1'($urandom); x.vs = 1'($urandom);
    return x;
  endfunction

  // Monitor: after each active edge, compare whatever is due now.
  initial begin
    vga_timing_t got;
    forever begin
      @(posedge clk);
      #1;
      edge_cnt++;
      while (xq.size() > 0 && xq[0].due <= edge_cnt) begin
        xy_exp_t e;
        e = xq.pop_front();
        n_checks++;
        if (char_xy !== e.xy || char_line !== e.line) begin
          n_fail++;
          $display("FAIL rom_addr@%0d: got xy=%h line=%h required xy=%h line=%h",
                   edge_cnt, char_xy, char_line, e.xy, e.line);
        end
      end
      while (oq.size() > 0 && oq[0].due <= edge_cnt) begin
        out_exp_t e;
        e = oq.pop_front();
        got = {vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out};
        n_checks++;
        if (rgb_out !== e.rgb || got !== e.t) begin
          n_fail++;
          $display("FAIL out@%0d: got rgb=%h timing=%h required rgb=%h timing=%h",
                   edge_cnt, rgb_out, got, e.rgb, e.t);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    // Pre-history counts as reset so early outputs are expected at zero.
    for (int i = 0; i < 3; i++) hist.push_back(mk(1'b1, 0, 0, 1'b0, 1'b0, '0));

    for (int i = 0; i < 3; i++) step(mk(1'b1, $urandom_range(0, 300), $urandom_range(0, 400),
                                        1'b0, 1'b0, 12'($urandom)));

    // Corners and edges of the text rectangle, plus blanking inside it.
    step(mk(1'b0, 48,  64,  1'b0, 1'b0, 12'h321));
    step(mk(1'b0, 175, 319, 1'b0, 1'b0, 12'h456));
    step(mk(1'b0, 176, 319, 1'b0, 1'b0, 12'h789));
    step(mk(1'b0, 100, 100, 1'b1, 1'b0, 12'h123));
    step(mk(1'b0, 100, 100, 1'b0, 1'b1, 12'h124));
    step(mk(1'b0, 47,  64,  1'b0, 1'b0, 12'hABC));
    step(mk(1'b0, 48,  63,  1'b0, 1'b0, 12'hDEF));
    step(mk(1'b0, 175, 320, 1'b0, 1'b0, 12'h135));
    step(mk(1'b0, 2047, 2047, 1'b0, 1'b0, 12'h246));

    // Full raster over the rectangle with a margin on every side.
    for (int v = 60; v < 324; v++) begin
      for (int h = 40; h < 184; h++) begin
        step(mk(1'b0, h, v, 1'b0, 1'b0, 12'($urandom)));
      end
    end

    // Reset in the middle of a stream.
    for (int i = 0; i < 10; i++) step(mk(1'b0, 60 + i, 70, 1'b0, 1'b0, 12'($urandom)));
    for (int i = 0; i < 3; i++)  step(mk(1'b1, 70 + i, 70, 1'b0, 1'b0, 12'($urandom)));
    for (int i = 0; i < 20; i++) step(mk(1'b0, 73 + i, 70, 1'b0, 1'b0, 12'($urandom)));

    // Random pixels biased toward the rectangle, with sporadic blanking.
    for (int i = 0; i < 3000; i++) begin
      int h, v;
      if ($urandom_range(0, 1) == 0) begin
        h = $urandom_range(30, 200);
        v = $urandom_range(50, 340);
      end else begin
        h = $urandom_range(0, 2047);
        v = $urandom_range(0, 2047);
      end
      step(mk($urandom_range(0, 199) == 0, h, v, $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0, 12'($urandom)));
    end

    // Drain the pipeline, bounded.
    for (int i = 0; i < 6; i++) step(mk(1'b0, 0, 0, 1'b1, 1'b1, '0));
    wait_cyc = 0;
    while ((xq.size() > 0 || oq.size() > 0) && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (xq.size() > 0 || oq.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", xq.size() + oq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_rect_char.md
Name: draw_rect_char

Overview:
- Initiator side of the character-ROM lookup.
- Walks a VGA timing stream and, for pixels inside a 16x16-character text rectangle, issues char_xy to the character ROM and the character line to the font ROM.
- Takes the returned 8-pixel font row and overlays text-coloured pixels on the incoming RGB stream.
- Sits between the background/rectangle drawing stages and the VGA output register.

Parameters:
- XPOS, 48, x of rectangle top-left pixel (11-bit range).
- YPOS, 64, y of rectangle top-left pixel (11-bit range).
- TEXT_COLOR, 12'hF_F_0, RGB444 colour of set font pixels.
- BG_COLOR, 12'h0_0_8, RGB444 rectangle fill; used only with the optional feature.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- vcount_in  in  11  vertical pixel count
- vsync_in  in  1  vertical sync
- vblnk_in  in  1  vertical blank
- hcount_in  in  11  horizontal pixel count
- hsync_in  in  1  horizontal sync
- hblnk_in  in  1  horizontal blank
- rgb_in  in  12  incoming pixel colour
- char_xy  out  8  {col[3:0], row[3:0]} to character ROM
- char_line  out  4  pixel row within character, to font ROM
- char_pixels  in  8  font row from font ROM; bit 7 is leftmost pixel
- vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out  out  11/1/1/11/1/1  timing delayed to match rgb_out
- rgb_out  out  12  composited colour

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset: every output register, every pipeline stage and all outputs go to 0, including char_xy, char_line and rgb_out.
- Geometry:
  - Character cell is 8x16 px; rectangle is 128x256 px.
  - in_rect = (hcount_in >= XPOS) && (hcount_in < XPOS+128) && (vcount_in >= YPOS) && (vcount_in < YPOS+256) && !hblnk_in && !vblnk_in.
  - dx = hcount_in-XPOS and dy = vcount_in-YPOS are computed in 11 bits and used only when in_rect, so no underflow is ever consumed.
- Stage 0 (registered into char_xy/char_line):
  - In rect: char_xy = {dx[6:3], dy[7:4]}; char_line = dy[3:0].
  - Outside rect: both are driven 0.
- Latency chain:
  - char ROM returns the code 1 cycle after char_xy.
  - font ROM returns char_pixels 1 cycle after that.
  - So char_pixels for a given pixel is valid 2 cycles after stage 0 registers it.
- Side pipeline: carries in_rect, dx[2:0], all timing signals and rgb_in for 3 stages. This covers 1 cycle for stage 0 plus 2 cycles of ROM latency; the output stage is registered.
- Output stage:
  - If delayed in_rect && char_pixels[7 - dx_d[2:0]]: rgb_out = TEXT_COLOR.
  - Otherwise rgb_out = delayed rgb.
  - Timing outputs are the same stage as rgb_out.
- Total latency: input to all *_out is exactly 4 clk. Every output signal gets an identical delay.
- Boundaries:
  - hcount_in = XPOS+127 is the last text pixel (col 15, bit 0).
  - XPOS+128 passes rgb through.
  - vcount_in = YPOS+255 is row 15, line 15.
- Reset mid-frame: the pipeline is flushed to 0. Outputs are zeros for 4 cycles after rst deasserts, then track input normally. There is no frame resynchronisation.
- Blanking: no overlay; rgb passes through unchanged.

Optional Feature:
- Macro: DRAW_RECT_CHAR_BG_EN.
- Defined: in-rect pixels whose font bit is 0 output BG_COLOR instead of the delayed rgb.
- Undefined: they pass the delayed rgb.
- Set font pixels output TEXT_COLOR in both cases.

Decomposition:
- Package char_pkg holds:
  - CHAR_W=8, CHAR_H=16, TEXT_COLS=16, TEXT_ROWS=16
  - HCNT_W=11, RGB_W=12
  - a packed struct vga_timing_t {vcount, vsync, vblnk, hcount, hsync, hblnk}
- Sub-module: delay (parameters WIDTH and CLK_DEL; synchronous active-high rst clears all stages). It carries the timing struct, rgb, in_rect and dx[2:0].

Test Plan:
- Apply rst for 3 cycles mid-stream -> all outputs 0 during reset and for 4 cycles after release; then hcount_out equals hcount_in from 4 cycles earlier.
- hcount_in=48, vcount_in=64, no blank -> next cycle char_xy=8'h00, char_line=0. Model returns char_pixels=8'h80 two cycles later -> rgb_out=12'hFF0 exactly 4 cycles after input.
- hcount_in=175, vcount_in=319 -> char_xy=8'hFF, char_line=15; char_pixels=8'h01 -> rgb_out=12'hFF0. hcount_in=176 -> rgb_out=rgb_in delayed, char_xy=0.
- hcount_in=100, vcount_in=100 with hblnk_in=1 -> char_xy=0; rgb_out equals delayed rgb_in=12'h123 regardless of char_pixels=8'hFF.
- Full frame with model ROMs (char ROM = all 'A', simple font ROM) -> golden compare of all 128x256 rect pixels; outside-rect pixels equal rgb_in.
- With DRAW_RECT_CHAR_BG_EN and char_pixels=8'h00 inside rect -> rgb_out=12'h008; without the macro -> rgb_out=rgb_in delayed.
